oversample_filter: RTL and testbench

Averaging front end that feeds the PID core. Accepts raw signed ADC samples with a one-cycle valid strobe, sums 2^os consecutive samples, divides by arithmetic right shift, and emits one averaged sample with a one-cycle `data_valid_out` pulse. The output pair drives the PID core's `data_in`/`data_valid_in` input directly. The oversample ratio is a frontpanel parameter and is latched on the same update handshake as the PID coefficients.

---
 rtl/oversample_filter.sv | 109 ++++++++++
 tb/tb_oversample_filter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/oversample_filter.sv
// Oversampling averager ahead of the PID core: sums 2^os signed samples, divides by an
// arithmetic right shift and emits one averaged sample with a single-cycle valid pulse.
module oversample_filter #(
  parameter int unsigned W_IN    = 18,
  parameter int unsigned W_OUT   = 18,
  parameter int unsigned W_OS    = 4,
  parameter int unsigned OS_INIT = 0
) (
  input  logic              clk_in,
  input  logic              reset_in,
  input  logic [W_IN-1:0]   data_in,
  input  logic              data_valid_in,
  input  logic [W_OS-1:0]   os_in,
  input  logic              clear_in,
  input  logic              update_en_in,
  input  logic              update_in,
  output logic [W_OUT-1:0]  data_out,
  output logic              data_valid_out
);

  localparam int unsigned CW = (1 << W_OS) - 1;
  localparam int unsigned AW = W_IN + CW;
  localparam logic [W_OS-1:0] OS_MAX = W_OS'(CW);

  localparam logic [1:0] ST_ACCUM = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

  logic [1:0]           state_q, state_d;
  logic [W_OS-1:0]      os_q, os_d;
  logic signed [AW-1:0] accum_q, accum_d;
  logic signed [AW-1:0] accum_sum, accum_shr;
  logic [CW-1:0]        count_q, count_d;
  logic [CW-1:0]        count_last;
  logic signed [W_IN-1:0] avg;
  logic [W_OUT-1:0]     data_out_q, data_out_d;

  // 2^os - 1 built as a right-shifted all-ones mask; os never exceeds CW.
  assign count_last = {CW{1'b1}} >> (OS_MAX - os_q);
  assign accum_sum  = accum_q + AW'($signed(data_in));
  assign accum_shr  = accum_q >>> os_q;
  assign avg        = accum_shr[W_IN-1:0];

  always_comb begin
    state_d    = state_q;
    os_d       = os_q;
    accum_d    = accum_q;
    count_d    = count_q;
    data_out_d = data_out_q;
    if (update_in && update_en_in) begin
      os_d    = os_in;
      accum_d = '0;
      count_d = '0;
      state_d = ST_ACCUM;
    end else if (clear_in) begin
      accum_d = '0;
      count_d = '0;
      state_d = ST_ACCUM;
    end else begin
      case (state_q)
        ST_ACCUM: begin
          if (data_valid_in) begin
            accum_d = accum_sum;
            if (count_q == count_last) begin
              count_d = '0;
              state_d = ST_SHIFT;
            end else begin
              count_d = count_q + CW'(1);
            end
          end
        end
        ST_SHIFT: begin
          data_out_d = W_OUT'(avg);
          state_d    = ST_SEND;
        end
        ST_SEND: begin
          accum_d = '0;
          state_d = ST_ACCUM;
        end
        default: begin
          accum_d = '0;
          count_d = '0;
          state_d = ST_ACCUM;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or posedge reset_in) begin
    if (reset_in) begin
      state_q    <= ST_ACCUM;
      os_q       <= W_OS'(OS_INIT);
      accum_q    <= '0;
      count_q    <= '0;
      data_out_q <= '0;
    end else begin
      state_q    <= state_d;
      os_q       <= os_d;
      accum_q    <= accum_d;
      count_q    <= count_d;
      data_out_q <= data_out_d;
    end
  end

  // Valid decodes straight from state so an async reset drops it immediately.
  assign data_valid_out = (state_q == ST_SEND);
  assign data_out       = data_out_q;

endmodule

// File: tb/tb_oversample_filter.sv
// Bench for oversample_filter: directed scenarios plus random traffic, every cycle compared
// against an arithmetic block-average model.
module tb_oversample_filter;

  localparam int unsigned W_IN    = 18;
  localparam int unsigned W_OUT   = 18;
  localparam int unsigned W_OS    = 4;
  localparam int unsigned OS_INIT = 0;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic [W_IN-1:0]  data_in = '0;
  logic             data_valid_in = 1'b0;
  logic [W_OS-1:0]  os_in = '0;
  logic             clear_in = 1'b0;
  logic             update_en_in = 1'b0;
  logic             update_in = 1'b0;
  logic [W_OUT-1:0] data_out;
  logic             data_valid_out;

  always #5 clk = ~clk;

  oversample_filter #(
    .W_IN    (W_IN),
    .W_OUT   (W_OUT),
    .W_OS    (W_OS),
    .OS_INIT (OS_INIT)
  ) dut (
    .clk_in         (clk),
    .reset_in       (rst),
    .data_in        (data_in),
    .data_valid_in  (data_valid_in),
    .os_in          (os_in),
    .clear_in       (clear_in),
    .update_en_in   (update_en_in),
    .update_in      (update_in),
    .data_out       (data_out),
    .data_valid_out (data_valid_out)
  );

  int     total = 0;
  int     bad = 0;
  int     pulses = 0;
  longint last_val = 0;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, obs, exp, $time);
    end
  endtask

  // Model: running sum/count of the current block; busy counts the two cycles after the
  // block-completing sample during which input is ignored and the result is presented.
  typedef struct {
    int     os;
    longint sum;
    longint cnt;
    int     busy;
    longint pend;
    longint data;
  } model_t;

  localparam model_t MODEL_INIT = '{os: OS_INIT, sum: 0, cnt: 0, busy: 0, pend: 0, data: 0};

  model_t m = MODEL_INIT;

  function automatic longint floor_div(input longint s, input longint dv);
    if (s >= 0) return s / dv;
    return -((-s + dv - 1) / dv);
  endfunction

  function automatic model_t step(input model_t cur, input logic v, input longint d,
                                  input logic clr, input logic upd, input logic en,
                                  input int osn);
    model_t n = cur;
    if (upd && en) begin
      n.os = osn; n.sum = 0; n.cnt = 0; n.busy = 0;
    end else if (clr) begin
      n.sum = 0; n.cnt = 0; n.busy = 0;
    end else if (cur.busy == 2) begin
      n.data = cur.pend; n.busy = 1;
    end else if (cur.busy == 1) begin
      n.busy = 0;
    end else if (v) begin
      n.sum = cur.sum + d;
      n.cnt = cur.cnt + 1;
      if (n.cnt == (longint'(1) << cur.os)) begin
        n.pend = floor_div(n.sum, longint'(1) << cur.os);
        n.sum = 0; n.cnt = 0; n.busy = 2;
      end
    end
    return n;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) m <= MODEL_INIT;
    else m <= step(m, data_valid_in, longint'($signed(data_in)), clear_in, update_in,
                   update_en_in, int'(os_in));
  end

  always @(negedge clk) begin
    check("valid", data_valid_out, (m.busy == 1));
    check("data", $signed(data_out), m.data);
    if (data_valid_out) begin
      pulses   <= pulses + 1;
      last_val <= longint'($signed(data_out));
    end
  end

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic send(input longint x, input int gap);
    data_in = x[W_IN-1:0];
    data_valid_in = 1'b1;
    cyc(1);
    data_valid_in = 1'b0;
    if (gap > 1) cyc(gap - 1);
  endtask

  task automatic set_os(input int v, input logic en);
    os_in = W_OS'(v);
    update_in = 1'b1;
    update_en_in = en;
    cyc(1);
    update_in = 1'b0;
    update_en_in = 1'b0;
  endtask

  task automatic stream(input longint x, input int n);
    data_in = x[W_IN-1:0];
    data_valid_in = 1'b1;
    cyc(n);
    data_valid_in = 1'b0;
  endtask

  int p0;

  initial begin
    #12 rst = 1'b0;
    cyc(1);
    check("reset_data", $signed(data_out), 0);
    check("reset_valid", data_valid_out, 0);

    // Passthrough
    set_os(0, 1'b1);
    p0 = pulses;
    send(5, 4); send(-7, 4); send(131071, 4);
    cyc(2);
    check("pass_cnt", pulses - p0, 3);
    check("pass_last", last_val, 131071);

    // Average of four
    set_os(2, 1'b1);
    p0 = pulses;
    send(100, 1); send(200, 1); send(300, 1);
    cyc(2);
    check("avg_early", pulses - p0, 0);
    send(400, 1);
    cyc(3);
    check("avg_cnt", pulses - p0, 1);
    check("avg_val", last_val, 250);

    // Floor toward -inf
    set_os(1, 1'b1);
    send(-1, 1); send(-2, 1);
    cyc(3);
    check("floor_val", last_val, -2);

    // Full scale at the maximum ratio
    set_os(15, 1'b1);
    p0 = pulses;
    stream(131071, 32768);
    cyc(3);
    check("fs_pos_cnt", pulses - p0, 1);
    check("fs_pos_val", last_val, 131071);
    stream(-131072, 32768);
    cyc(3);
    check("fs_neg_val", last_val, -131072);

    // Clear, coincident sample, samples during the shift/send window
    set_os(2, 1'b1);
    p0 = pulses;
    send(10, 1); send(20, 1);
    data_in = W_IN'(999); data_valid_in = 1'b1; clear_in = 1'b1;
    cyc(1);
    clear_in = 1'b0;
    for (int i = 1; i <= 4; i++) begin
      data_in = W_IN'(i); cyc(1);
    end
    data_in = W_IN'(1000);
    cyc(2);
    data_valid_in = 1'b0;
    cyc(3);
    check("clr_cnt", pulses - p0, 1);
    check("clr_val", last_val, 2);
    check("clr_partial", m.cnt, 0);

    // Update mid-block
    set_os(3, 1'b1);
    p0 = pulses;
    send(50, 1); send(50, 1); send(50, 1);
    set_os(1, 1'b1);
    send(6, 1); send(8, 1);
    cyc(3);
    check("upd_cnt", pulses - p0, 1);
    check("upd_val", last_val, 7);

    // Update ignored when not enabled: os stays 3
    set_os(3, 1'b1);
    p0 = pulses;
    send(16, 1); send(16, 1); send(16, 1);
    set_os(1, 1'b0);
    send(16, 1); send(16, 1);
    cyc(4);
    check("upd_dis_cnt", pulses - p0, 0);
    send(16, 1); send(16, 1); send(16, 1);
    cyc(3);
    check("upd_dis_cnt2", pulses - p0, 1);
    check("upd_dis_val", last_val, 16);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      data_valid_in = 1'($urandom_range(0, 1));
      data_in       = W_IN'($urandom);
      clear_in      = ($urandom_range(0, 49) == 0);
      update_in     = ($urandom_range(0, 59) == 0);
      update_en_in  = 1'($urandom_range(0, 1));
      os_in         = W_OS'($urandom_range(0, 3));
      cyc(1);
    end
    data_valid_in = 1'b0; clear_in = 1'b0; update_in = 1'b0; update_en_in = 1'b0;
    cyc(3);

    // Asynchronous reset during the send cycle
    set_os(1, 1'b1);
    send(40, 1); send(42, 1);
    @(posedge clk);
    #3;
    check("prerst_valid", data_valid_out, 1);
    check("prerst_data", $signed(data_out), 41);
    rst = 1'b1;
    #1;
    check("arst_valid", data_valid_out, 0);
    check("arst_data", $signed(data_out), 0);
    #3 rst = 1'b0;
    cyc(1);
    p0 = pulses;
    send(33, 4);
    check("post_rst_cnt", pulses - p0, 1);
    check("post_rst_val", last_val, 33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
